mem_master: RTL and testbench

- Initiator side of the single-port word memory: accepts read/write burst requests from the CPU/loader, sequences addresses and drives `mem_addr`, `mem_data_in` and `mem_en_write`.
- Read data is returned on a valid/ready stream; write data is consumed from a valid/ready stream.
- The memory it drives has a combinational read (`data_out` follows `addr` in the same cycle) and a synchronous write on the rising clock edge.
- Sits between the control unit and the memory instance.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_master.sv | 90 +++++++++
 tb/tb_mem_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory burst master.
package mem_pkg;

    localparam int WORD_SIZE_DEF = 8;
    localparam int ADDR_SIZE_DEF = 8;
    localparam int LEN_SIZE_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } mem_state_t;

    // Highest address reachable with an address bus of the given width.
    function automatic logic [31:0] max_addr(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/mem_master.sv
// Burst initiator for a single-port word memory with combinational read and
// clocked write; read beats leave on a valid/ready stream, write beats arrive on one.
module mem_master
    import mem_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int LEN_SIZE  = LEN_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [LEN_SIZE-1:0]  req_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [WORD_SIZE-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 rd_last,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_data_in,
    output logic                 mem_en_write,
    input  logic [WORD_SIZE-1:0] mem_data_out
);

    localparam logic [ADDR_SIZE-1:0] MAX_ADDR = ADDR_SIZE'(max_addr(ADDR_SIZE));

    mem_state_t           state_q;
    logic [ADDR_SIZE-1:0] cur_addr_q;
    logic [ADDR_SIZE-1:0] cur_addr_d;
    logic [LEN_SIZE-1:0]  remaining_q;
    logic                 done_q;
    logic                 beat;
    logic                 last_beat;

    // A beat is a read handshake or any valid write word; both advance identically.
    assign beat      = ((state_q == ST_READ) && rd_ready) ||
                       ((state_q == ST_WRITE) && wr_valid);
    assign last_beat = beat && (remaining_q == '0);
    assign cur_addr_d = (cur_addr_q == MAX_ADDR) ? '0 : cur_addr_q + ADDR_SIZE'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        cur_addr_q  <= req_addr;
                        remaining_q <= req_len;
                        state_q     <= req_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (last_beat) begin
                        // Address stays on the final word; the next request reloads it.
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else if (beat) begin
                        cur_addr_q  <= cur_addr_d;
                        remaining_q <= remaining_q - LEN_SIZE'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign rd_valid     = (state_q == ST_READ);
    assign rd_data      = mem_data_out;
    assign rd_last      = (state_q == ST_READ) && (remaining_q == '0);
    assign wr_ready     = (state_q == ST_WRITE);
    assign mem_addr     = cur_addr_q;
    assign mem_data_in  = wr_data;
    assign mem_en_write = (state_q == ST_WRITE) && wr_valid;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master driving a behavioural single-port memory;
// read data is checked against a scoreboard filled from a reference image.
module tb_mem_master;

    logic       clk;
    logic       rst_n;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready, rd_last;
    logic [7:0] rd_data;
    logic       busy, done;
    logic [7:0] mem_addr, mem_data_in, mem_data_out;
    logic       mem_en_write;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] sb_q    [$];
    logic [7:0] exp_addr;
    int         checks   = 0;
    int         failures = 0;
    int         busy_cycles;

    mem_master #(.WORD_SIZE(8), .ADDR_SIZE(8), .LEN_SIZE(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_en_write (mem_en_write),
        .mem_data_out (mem_data_out)
    );

    // Memory: combinational read, write on rising edge.
    assign mem_data_out = mem[mem_addr];
    always @(posedge clk) if (mem_en_write) mem[mem_addr] <= mem_data_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a request; returns at the first negedge of the burst.
    task automatic issue(input bit wr, input logic [7:0] a, input logic [7:0] l);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
        #1;
        chk("req_ready_idle", req_ready, 1);
        if (!wr) for (int i = 0; i <= int'(l); i++) sb_q.push_back(ref_mem[8'(int'(a) + i)]);
        exp_addr = a;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wbeat(input logic [7:0] d, input bit v);
        wr_valid = v; wr_data = d;
        #1;
        chk("wr_ready", wr_ready, 1);
        chk("wr_en", mem_en_write, v);
        chk("wr_addr", mem_addr, exp_addr);
        if (busy) busy_cycles++;
        $display("write beat addr=%02h data=%02h valid=%0d", mem_addr, d, v);
        if (v) begin
            ref_mem[exp_addr] = d;
            exp_addr++;
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic rbeat(input bit rdy, input bit last);
        logic [7:0] e;
        rd_ready = rdy;
        #1;
        chk("rd_valid", rd_valid, 1);
        chk("rd_addr", mem_addr, exp_addr);
        chk("rd_en_low", mem_en_write, 0);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else if (rdy) begin
            e = sb_q.pop_front();
            chk("rd_data", rd_data, e);
            chk("rd_last", rd_last, last);
            $display("read beat addr=%02h data=%02h last=%0d", mem_addr, rd_data, rd_last);
            exp_addr++;
        end else begin
            chk("rd_hold", rd_data, sb_q[0]);
        end
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic done_cycle();
        #1;
        chk("done_pulse", done, 1);
        chk("busy_idle", busy, 0);
        chk("req_ready_done", req_ready, 1);
        chk("en_idle", mem_en_write, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        rst_n = 1'b0; req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_en", mem_en_write, 0);
        chk("rst_last", rd_last, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single write then single read
        issue(1, 8'h10, 0);
        wbeat(8'hA5, 1);
        done_cycle();
        chk("t1_mem", mem[8'h10], 8'hA5);
        @(negedge clk);
        chk("t1_done_clear", done, 0);
        issue(0, 8'h10, 0);
        rbeat(1, 1);
        done_cycle();
        @(negedge clk);

        // 2: wrapping write burst with a gap
        busy_cycles = 0;
        issue(1, 8'hFE, 3);
        wbeat(8'h11, 1);
        wbeat(8'h00, 0);
        wbeat(8'h22, 1);
        wbeat(8'h33, 1);
        wbeat(8'h44, 1);
        done_cycle();
        chk("t2_busy_cycles", busy_cycles, 5);
        chk("t2_mem_fe", mem[8'hFE], 8'h11);
        chk("t2_mem_ff", mem[8'hFF], 8'h22);
        chk("t2_mem_00", mem[8'h00], 8'h33);
        chk("t2_mem_01", mem[8'h01], 8'h44);
        @(negedge clk);

        // 3: read burst with back-pressure on beat 1
        issue(0, 8'hFE, 3);
        rbeat(1, 0);
        rbeat(0, 0);
        chk("t3_hold_addr", mem_addr, 8'hFF);
        rbeat(0, 0);
        rbeat(1, 0);
        rbeat(1, 0);
        rbeat(1, 1);
        done_cycle();
        @(negedge clk);

        // 4: request held during a burst, accepted in the done cycle
        issue(1, 8'h20, 1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40; req_len = 0;
        #1;
        chk("t4_req_ready_busy", req_ready, 0);
        wbeat(8'h55, 1);
        chk("t4_req_ready_busy2", req_ready, 0);
        wbeat(8'h66, 1);
        done_cycle();
        sb_q.push_back(ref_mem[8'h40]);
        exp_addr = 8'h40;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t4_second_busy", busy, 1);
        chk("t4_mem_21", mem[8'h21], 8'h66);
        rbeat(1, 1);
        done_cycle();
        @(negedge clk);

        // 5: reset mid write burst
        issue(1, 8'h80, 5);
        wbeat(8'hA1, 1);
        wbeat(8'hA2, 1);
        wr_valid = 1'b1; wr_data = 8'hA3;
        #1;
        chk("t5_en_before", mem_en_write, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_en_rst", mem_en_write, 0);
        chk("t5_busy_rst", busy, 0);
        chk("t5_wr_ready_rst", wr_ready, 0);
        @(negedge clk);
        rst_n = 1'b1; wr_valid = 1'b0;
        #1;
        chk("t5_req_ready", req_ready, 1);
        chk("t5_mem_80", mem[8'h80], 8'hA1);
        chk("t5_mem_81", mem[8'h81], 8'hA2);
        chk("t5_mem_82", mem[8'h82], 8'h82 ^ 8'h5A);
        @(negedge clk);

        // 6: maximum length read across the whole address space
        issue(0, 8'h00, 8'hFF);
        for (int i = 0; i < 256; i++) rbeat(1, i == 255);
        done_cycle();
        chk("t6_final_addr", mem_addr, 8'hFF);
        chk("t6_sb_drained", sb_q.size(), 0);
        @(negedge clk);
        chk("t6_done_clear", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
